// File: rtl/storage_pkg.sv
// Shared definitions for the storage/playback sequencer: FSM encoding and default data width.
package storage_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SHOW = 1'b1;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_SHOW = ST_SHOW
    } state_t;

endpackage

// File: rtl/button_edge_detect.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous board button.
module button_edge_detect
    import storage_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic sync_r;
    logic sync_rr;
    logic sampled;
    logic armed;

    // A button already high when reset is released must drop to 0 before it can
    // generate a pulse, so the detector only arms after a real low sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r  <= 1'b0;
            sync_rr <= 1'b0;
            sampled <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sync_r  <= btn;
            sync_rr <= sync_r;
            sampled <= 1'b1;
            if (sampled && !sync_r) begin
                armed <= 1'b1;
            end
        end
    end

    assign pulse = sync_r & ~sync_rr & armed;

endmodule

// File: rtl/storage_playback_controller.sv
// Ring-buffer sequencer: queues switch values on WRITE, plays them back oldest-first on TRANSFER.
module storage_playback_controller
    import storage_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         switches,
    input  logic                     write_button,
    input  logic                     transfer_button,
    input  logic                     clear_button,
    output logic [WIDTH-1:0]         red_leds,
    output logic [WIDTH-1:0]         green_leds,
    output logic [$clog2(DEPTH):0]   level_leds,
    output logic                     busy,
    output logic                     error_led
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [CW-1:0] FULL_C    = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    logic wr_pulse;
    logic tr_pulse;
    logic clr_pulse;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [HW-1:0]    hold_cnt;

    logic             do_write;
    logic             write_drop;
    logic             retire;
    logic             start;
    logic             empty_err;
    logic [CW-1:0]    remaining;
    logic [WIDTH-1:0] next_entry;

    button_edge_detect u_write_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (write_button),
        .pulse (wr_pulse)
    );

    button_edge_detect u_transfer_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (transfer_button),
        .pulse (tr_pulse)
    );

    button_edge_detect u_clear_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (clear_button),
        .pulse (clr_pulse)
    );

    always_comb begin
        do_write   = wr_pulse && (count != FULL_C);
        write_drop = wr_pulse && (count == FULL_C);
        retire     = (state == S_SHOW) && (hold_cnt == HOLD_LAST);
        start      = (state == S_IDLE) && tr_pulse && (count != '0);
        empty_err  = (state == S_IDLE) && tr_pulse && (count == '0);

        remaining = count;
        if (do_write) begin
            remaining = remaining + ONE_C;
        end
        if (retire) begin
            remaining = remaining - ONE_C;
        end

        // With one entry left, a write landing on the retire cycle becomes the
        // next head before it has reached the memory array.
        next_entry = (count == ONE_C) ? switches : mem[rd_ptr + PTR_ONE];

        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SHOW;
                end
            end
            S_SHOW: begin
                if (retire && (remaining == '0)) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (clr_pulse) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !clr_pulse && do_write) begin
            mem[wr_ptr] <= switches;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_pulse) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hold_cnt   <= '0;
            red_leds   <= '0;
            green_leds <= '0;
            error_led  <= 1'b0;
        end else begin
            count <= remaining;
            if (do_write) begin
                red_leds <= switches;
                wr_ptr   <= wr_ptr + PTR_ONE;
            end
            if (write_drop || empty_err) begin
                error_led <= 1'b1;
            end
            if (start) begin
                green_leds <= mem[rd_ptr];
                hold_cnt   <= '0;
            end else if (retire) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                hold_cnt <= '0;
                if (remaining != '0) begin
                    green_leds <= next_entry;
                end
            end else if (state == S_SHOW) begin
                hold_cnt <= hold_cnt + HOLD_ONE;
            end
        end
    end

    assign level_leds = count;
    assign busy       = (state == S_SHOW);

endmodule

// File: tb/tb_storage_playback_controller.sv
// Bench for storage_playback_controller: directed scenarios plus random button traffic vs a queue model.
module tb_storage_playback_controller;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int HOLD  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] switches;
    logic             write_button;
    logic             transfer_button;
    logic             clear_button;
    logic [WIDTH-1:0] red_leds;
    logic [WIDTH-1:0] green_leds;
    logic [2:0]       level_leds;
    logic             busy;
    logic             error_led;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the queue contents, displayed values and playback progress.
    logic [7:0] mq[$];
    logic [7:0] m_red;
    logic [7:0] m_green;
    bit         m_err;
    bit         m_show;
    int         m_tick;
    // Per button: the two most recent post-reset samples and whether each exists.
    bit         h1[3];
    bit         h1v[3];
    bit         h2[3];
    bit         h2v[3];

    always #5 clk = ~clk;

    storage_playback_controller #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .switches        (switches),
        .write_button    (write_button),
        .transfer_button (transfer_button),
        .clear_button    (clear_button),
        .red_leds        (red_leds),
        .green_leds      (green_leds),
        .level_leds      (level_leds),
        .busy            (busy),
        .error_led       (error_led)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_red   = '0;
        m_green = '0;
        m_err   = 1'b0;
        m_show  = 1'b0;
        m_tick  = 0;
    endtask

    task automatic model_edge();
        bit         b[3];
        bit         p[3];
        logic [7:0] sw;
        bit         full;
        bit         was_empty;
        bit         ret;
        b[0] = write_button;
        b[1] = transfer_button;
        b[2] = clear_button;
        sw   = switches;
        if (reset) begin
            model_clear();
            for (int i = 0; i < 3; i++) begin
                h1[i] = 0; h1v[i] = 0; h2[i] = 0; h2v[i] = 0;
            end
            return;
        end
        // A press acts on the 2nd edge after a 0->1 seen between two post-reset samples.
        for (int i = 0; i < 3; i++) begin
            p[i]   = h1v[i] && h2v[i] && h1[i] && !h2[i];
            h2[i]  = h1[i];
            h2v[i] = h1v[i];
            h1[i]  = b[i];
            h1v[i] = 1;
        end
        if (p[2]) begin
            model_clear();
            return;
        end
        full      = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        ret       = m_show && (m_tick == HOLD - 1);
        if (ret) void'(mq.pop_front());
        if (p[0]) begin
            if (full) m_err = 1'b1;
            else begin
                mq.push_back(sw);
                m_red = sw;
            end
        end
        if (m_show) begin
            if (ret) begin
                m_tick = 0;
                if (mq.size() > 0) m_green = mq[0];
                else m_show = 1'b0;
            end else begin
                m_tick++;
            end
        end else if (p[1]) begin
            if (!was_empty) begin
                m_show  = 1'b1;
                m_green = mq[0];
                m_tick  = 0;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("red_leds",   32'(red_leds),   32'(m_red));
        chk("green_leds", 32'(green_leds), 32'(m_green));
        chk("level_leds", 32'(level_leds), 32'(mq.size()));
        chk("busy",       32'(busy),       32'(m_show));
        chk("error_led",  32'(error_led),  32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic press_write(input logic [7:0] v);
        switches = v;
        write_button = 1'b1;
        tick();
        write_button = 1'b0;
        tick();
    endtask

    task automatic press_transfer();
        transfer_button = 1'b1;
        tick();
        transfer_button = 1'b0;
        tick();
    endtask

    task automatic press_clear();
        clear_button = 1'b1;
        tick();
        clear_button = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        switches = '0;
        write_button = 1'b0;
        transfer_button = 1'b0;
        clear_button = 1'b0;
        tick();
        tick();
        chk("reset_level", 32'(level_leds), 32'd0);
        chk("reset_green", 32'(green_leds), 32'd0);
        reset = 1'b0;
        cycles(3);

        // Three entries played back in order, last one left on display.
        press_write(8'h11);
        press_write(8'h22);
        press_write(8'h33);
        press_transfer();
        cycles(14);
        chk("t1_green_last", 32'(green_leds), 32'h33);
        chk("t1_level_empty", 32'(level_leds), 32'd0);
        chk("t1_busy_done", 32'(busy), 32'd0);

        // Overfill: fifth write dropped and flagged.
        press_clear();
        for (int i = 0; i < 5; i++) press_write(8'hA0 + 8'(i));
        chk("t2_level_full", 32'(level_leds), 32'd4);
        chk("t2_red_last_ok", 32'(red_leds), 32'hA3);
        chk("t2_error", 32'(error_led), 32'd1);
        press_transfer();
        cycles(18);
        chk("t2_green_last", 32'(green_leds), 32'hA3);

        // Write during playback joins the same run.
        press_clear();
        press_write(8'h01);
        press_write(8'h02);
        press_transfer();
        press_write(8'h03);
        cycles(14);
        chk("t3_green_last", 32'(green_leds), 32'h03);

        // Sweep a write across the retire cycle, from full and from three entries.
        for (int base = 3; base <= 4; base++) begin
            for (int off = 0; off < 6; off++) begin
                press_clear();
                for (int i = 0; i < base; i++) press_write(8'($urandom));
                transfer_button = 1'b1;
                tick();
                transfer_button = 1'b0;
                tick();
                cycles(off);
                switches = 8'($urandom);
                write_button = 1'b1;
                tick();
                write_button = 1'b0;
                tick();
                if (off == 2) begin
                    chk("t4_retire_level", 32'(level_leds), 32'd3);
                    chk("t4_retire_error", 32'(error_led), (base == 4) ? 32'd1 : 32'd0);
                end
                cycles(20);
            end
        end

        // Transfer on empty flags an error; clear wipes everything.
        press_clear();
        press_transfer();
        chk("t5_error", 32'(error_led), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        press_write(8'h5A);
        press_clear();
        chk("t5_clr_error", 32'(error_led), 32'd0);
        chk("t5_clr_red", 32'(red_leds), 32'd0);
        chk("t5_clr_level", 32'(level_leds), 32'd0);

        // Reset during playback with WRITE held through reset.
        press_write(8'h77);
        press_write(8'h88);
        press_transfer();
        cycles(2);
        switches = 8'h44;
        write_button = 1'b1;
        cycles(2);
        reset = 1'b1;
        tick();
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_red", 32'(red_leds), 32'd0);
        tick();
        reset = 1'b0;
        cycles(5);
        chk("t6_held_no_enqueue", 32'(level_leds), 32'd0);
        write_button = 1'b0;
        cycles(2);
        switches = 8'h99;
        write_button = 1'b1;
        cycles(2);
        chk("t6_fresh_level", 32'(level_leds), 32'd1);
        chk("t6_fresh_red", 32'(red_leds), 32'h99);
        write_button = 1'b0;
        tick();

        // Random button traffic against the model.
        press_clear();
        for (int i = 0; i < 800; i++) begin
            write_button    = ($urandom_range(0, 2) == 0);
            transfer_button = ($urandom_range(0, 11) == 0);
            clear_button    = ($urandom_range(0, 99) == 0);
            reset           = ($urandom_range(0, 399) == 0);
            switches        = 8'($urandom);
            tick();
        end
        reset = 1'b0;
        write_button = 1'b0;
        transfer_button = 1'b0;
        clear_button = 1'b0;
        cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
